manchester_encoder: RTL and testbench



---
 rtl/manchester_encoder_if.sv | 15 +
 rtl/manchester_encoder.sv | 178 +++++++++++++++++
 tb/tb_manchester_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/manchester_encoder_if.sv
// Stream handshake bundle feeding the Manchester encoder.
//   tdata  : word to transmit (FRAME_SIZE bits)
//   tvalid : word valid, driven by the source
//   tready : encoder can accept a word, driven by the encoder
// Modports: master = stream source, slave = encoder.
interface manchester_encoder_if #(
    parameter int FRAME_SIZE = 8
);
    logic [FRAME_SIZE-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/manchester_encoder.sv
// Manchester transmitter fed by a stream handshake. Each accepted word is sent
// as a start bit '1' followed by FRAME_SIZE data bits MSB first, then a
// minimum idle-low gap. Bit '1' = low half then high half, bit '0' = high half
// then low half, idle = low.
// Ports:
//   aclk           : clock, rising edge
//   aresetn        : asynchronous active-low reset
//   s_axis         : stream slave (tdata, tvalid in; tready out, registered)
//   manchester_out : encoded serial line, registered
//   busy           : high from accept until the end of the gap, registered
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | line low, tready high, waiting for a handshake
// ST_START| sending the start bit (low half, high half)
// ST_DATA | sending data bits MSB first, r_idx = bit number
// ST_GAP  | line low for GAP_HALF_BITS half-bits, r_idx = half number
module manchester_encoder #(
    parameter int FRAME_SIZE        = 8,
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int GAP_HALF_BITS     = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    manchester_encoder_if.slave   s_axis,
    output logic                  manchester_out,
    output logic                  busy
);

    localparam int CNT_W   = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam int IDX_MAX = (FRAME_SIZE > GAP_HALF_BITS) ? FRAME_SIZE : GAP_HALF_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(FRAME_SIZE - 1);
    localparam logic [IDX_W-1:0] GAP_LAST   = IDX_W'(GAP_HALF_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_half, w_half_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [FRAME_SIZE-1:0] r_shift, w_shift_nxt;
    logic                  r_out, w_out_nxt;
    logic                  r_tready, w_tready_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [FRAME_SIZE-1:0] w_shift_sh;
    logic                  w_tc;

    assign w_shift_sh = {r_shift[FRAME_SIZE-2:0], 1'b0};
    assign w_tc       = (r_cnt == '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_half   <= 1'b0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_out    <= 1'b0;
            r_tready <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_half   <= w_half_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_out    <= w_out_nxt;
            r_tready <= w_tready_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Outputs are registered, so each branch computes the line level for the
    // cycle that follows the transition it takes.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_half_nxt   = r_half;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_out_nxt    = r_out;
        w_tready_nxt = 1'b0;
        w_busy_nxt   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_out_nxt    = 1'b0;
                w_tready_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (s_axis.tvalid && r_tready) begin
                    w_shift_nxt  = s_axis.tdata;
                    w_cnt_nxt    = CNT_RELOAD;
                    w_half_nxt   = 1'b0;
                    w_idx_nxt    = '0;
                    w_state_nxt  = ST_START;
                    w_out_nxt    = 1'b0;
                    w_tready_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
                end
            end

            ST_START: begin
                if (w_tc) begin
                    w_cnt_nxt = CNT_RELOAD;
                    if (!r_half) begin
                        w_half_nxt = 1'b1;
                        w_out_nxt  = 1'b1;
                    end else begin
                        w_half_nxt  = 1'b0;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DATA;
                        w_out_nxt   = ~r_shift[FRAME_SIZE-1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (w_tc) begin
                    w_cnt_nxt = CNT_RELOAD;
                    if (!r_half) begin
                        w_half_nxt = 1'b1;
                        w_out_nxt  = r_shift[FRAME_SIZE-1];
                    end else begin
                        w_half_nxt  = 1'b0;
                        w_shift_nxt = w_shift_sh;
                        if (r_idx == DATA_LAST) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = ST_GAP;
                            w_out_nxt   = 1'b0;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                            w_out_nxt = ~w_shift_sh[FRAME_SIZE-1];
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            ST_GAP: begin
                w_out_nxt = 1'b0;
                if (w_tc) begin
                    w_cnt_nxt = CNT_RELOAD;
                    if (r_idx == GAP_LAST) begin
                        w_idx_nxt    = '0;
                        w_state_nxt  = ST_IDLE;
                        w_tready_nxt = 1'b1;
                        w_busy_nxt   = 1'b0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_out_nxt   = 1'b0;
            end
        endcase
    end

    assign s_axis.tready  = r_tready;
    assign manchester_out = r_out;
    assign busy           = r_busy;

endmodule

// File: tb/tb_manchester_encoder.sv
// Directed bench for manchester_encoder at default parameters
// (8 data bits, 4 clocks per half-bit, 4 gap half-bits => 88-cycle frame).
module tb_manchester_encoder;

    logic aclk = 1'b0;
    logic aresetn;
    logic mo;
    logic bsy;

    int n_pass  = 0;
    int n_total = 0;

    manchester_encoder_if #(.FRAME_SIZE(8)) s_if ();

    manchester_encoder #(
        .FRAME_SIZE       (8),
        .CLKS_PER_HALF_BIT(4),
        .GAP_HALF_BITS    (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis        (s_if),
        .manchester_out(mo),
        .busy          (bsy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Half-bit image of one frame: start, 8 data bits, 4 gap halves.
    function automatic logic [21:0] model(input logic [7:0] d);
        logic [21:0] h;
        h = '0;
        h[21] = 1'b0;
        h[20] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            h[19-2*i] = ~d[7-i];
            h[18-2*i] = d[7-i];
        end
        return h;
    endfunction

    function automatic logic [87:0] expand(input logic [21:0] h);
        logic [87:0] e;
        for (int k = 0; k < 88; k++) e[87-k] = h[21 - k/4];
        return e;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (s_if.tready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("ready_wait", {87'd0, s_if.tready}, 88'd1);
    endtask

    // Leaves the bench in the cycle right after the handshake edge.
    task automatic handshake(input logic [7:0] d);
        wait_ready();
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        tick();
    endtask

    task automatic capture(input bit jitter, output logic [87:0] line,
                           output logic [87:0] rdy, output logic [87:0] bz);
        for (int k = 0; k < 88; k++) begin
            line[87-k] = mo;
            rdy[87-k]  = s_if.tready;
            bz[87-k]   = bsy;
            if (jitter) begin
                s_if.tvalid = 1'($urandom);
                s_if.tdata  = 8'($urandom);
            end
            tick();
        end
    endtask

    logic [87:0] line, rdy, bz;
    logic        acc_mo, acc_busy;

    initial begin
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_out", {87'd0, mo}, 88'd0);
        chk("rst_tready", {87'd0, s_if.tready}, 88'd0);
        chk("rst_busy", {87'd0, bsy}, 88'd0);
        aresetn = 1'b1;
        #1;
        chk("tready_before_edge", {87'd0, s_if.tready}, 88'd0);
        tick();
        chk("tready_first_edge", {87'd0, s_if.tready}, 88'd1);
        acc_mo   = 1'b0;
        acc_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            acc_mo   = acc_mo | mo;
            acc_busy = acc_busy | bsy;
            tick();
        end
        chk("idle_line", {87'd0, acc_mo}, 88'd0);
        chk("idle_busy", {87'd0, acc_busy}, 88'd0);

        // 0xA5 against a hand-written half-bit image
        handshake(8'hA5);
        s_if.tvalid = 1'b0;
        capture(1'b0, line, rdy, bz);
        chk("a5_line", line, expand(22'b01_01_10_01_10_10_01_10_01_0000));
        chk("a5_tready_low", rdy, 88'd0);
        chk("a5_busy_high", bz, {88{1'b1}});
        chk("a5_tready_back", {87'd0, s_if.tready}, 88'd1);
        chk("a5_busy_back", {87'd0, bsy}, 88'd0);

        // 0x00 then 0xFF back to back with tvalid held high
        handshake(8'h00);
        s_if.tdata = 8'hFF;
        capture(1'b0, line, rdy, bz);
        chk("b2b_00_line", line, expand(22'b01_1010101010101010_0000));
        chk("b2b_tready_at_89", {87'd0, s_if.tready}, 88'd1);
        tick();
        s_if.tvalid = 1'b0;
        chk("b2b_accepted_tready", {87'd0, s_if.tready}, 88'd0);
        chk("b2b_accepted_busy", {87'd0, bsy}, 88'd1);
        capture(1'b0, line, rdy, bz);
        chk("b2b_ff_line", line, expand(22'b01_0101010101010101_0000));

        // Async reset while bit 3 of 0x3C is in its high half
        handshake(8'h3C);
        s_if.tvalid = 1'b0;
        for (int j = 0; j < 37; j++) tick();
        chk("pre_reset_line", {87'd0, mo}, 88'd1);
        #1;
        aresetn = 1'b0;
        #1;
        chk("async_rst_line", {87'd0, mo}, 88'd0);
        chk("async_rst_busy", {87'd0, bsy}, 88'd0);
        repeat (2) tick();
        aresetn = 1'b1;
        #1;
        chk("post_rst_tready_low", {87'd0, s_if.tready}, 88'd0);
        tick();
        chk("post_rst_tready_high", {87'd0, s_if.tready}, 88'd1);
        handshake(8'h81);
        s_if.tvalid = 1'b0;
        capture(1'b0, line, rdy, bz);
        chk("post_rst_81_line", line, expand(model(8'h81)));

        // Random tvalid/tdata activity while the frame is in flight
        handshake(8'h5A);
        capture(1'b1, line, rdy, bz);
        s_if.tvalid = 1'b0;
        chk("jitter_5a_line", line, expand(model(8'h5A)));
        chk("jitter_no_early_accept", rdy, 88'd0);
        chk("jitter_busy_high", bz, {88{1'b1}});
        tick();
        chk("jitter_idle_after", {86'd0, s_if.tready, bsy}, 88'd2);

        // tvalid pulse dropped before any edge sees it: no frame
        s_if.tvalid = 1'b1;
        #2;
        s_if.tvalid = 1'b0;
        acc_mo = 1'b0;
        for (int i = 0; i < 12; i++) begin
            acc_mo = acc_mo | mo | bsy;
            tick();
        end
        chk("no_partial_frame", {87'd0, acc_mo}, 88'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
